// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache fill controller.
// Block address is pc[15:3]: index in the low bits, tag in the high bits.
package icache_fill_ctrl_pkg;

    localparam int ICACHE_INDEX_BITS = 5;
    localparam int ICACHE_TAG_BITS   = 8;
    localparam int BLOCK_BITS        = ICACHE_INDEX_BITS + ICACHE_TAG_BITS;
    localparam int MEM_TAG_BITS      = 4;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } bus_cmd_t;

    typedef enum logic {
        FILL_IDLE,
        FILL_ISSUE
    } fill_state_t;

    typedef struct packed {
        logic                    valid;
        logic [MEM_TAG_BITS-1:0] mem_tag;
        logic [BLOCK_BITS-1:0]   block;
    } mshr_entry_t;

endpackage

// File: rtl/icache_mshr_table.sv
// Outstanding-request table: allocates the lowest free entry, frees on a
// matching memory tag, and answers block-membership lookups.
module icache_mshr_table
    import icache_fill_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_en,
    input  logic [MEM_TAG_BITS-1:0] alloc_tag,
    input  logic [BLOCK_BITS-1:0]   alloc_block,
    input  logic [MEM_TAG_BITS-1:0] fill_tag,
    output logic                    fill_hit,
    output logic [BLOCK_BITS-1:0]   fill_block,
    input  logic [BLOCK_BITS-1:0]   lookup_block_a,
    output logic                    lookup_hit_a,
    input  logic [BLOCK_BITS-1:0]   lookup_block_b,
    output logic                    lookup_hit_b,
    output logic                    full
);

    mshr_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] fill_match;
    logic [DEPTH-1:0] alloc_onehot;
    logic             has_free;

    // Free-slot search uses pre-fill validity, so a slot freed this cycle
    // only becomes allocatable on the next one.
    always_comb begin
        fill_hit     = 1'b0;
        fill_block   = '0;
        fill_match   = '0;
        lookup_hit_a = 1'b0;
        lookup_hit_b = 1'b0;
        alloc_onehot = '0;
        has_free     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                if (fill_tag != '0 && entries[i].mem_tag == fill_tag) begin
                    fill_match[i] = 1'b1;
                    if (!fill_hit) begin
                        fill_hit   = 1'b1;
                        fill_block = entries[i].block;
                    end
                end
                if (entries[i].block == lookup_block_a) lookup_hit_a = 1'b1;
                if (entries[i].block == lookup_block_b) lookup_hit_b = 1'b1;
            end else if (!has_free) begin
                has_free        = 1'b1;
                alloc_onehot[i] = 1'b1;
            end
        end
    end

    assign full = ~has_free;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fill_match[i]) begin
                    entries[i].valid <= 1'b0;
                end else if (alloc_en && alloc_onehot[i]) begin
                    entries[i].valid   <= 1'b1;
                    entries[i].mem_tag <= alloc_tag;
                    entries[i].block   <= alloc_block;
                end
            end
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// 3-wide icache miss/fill controller: read-port addressing, demand-miss
// detection, block load plus sequential prefetch issue, and fill write-back.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int MSHR_DEPTH     = 4,
    parameter int PREFETCH_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0][31:0] fetch_pc,
    input  logic [2:0]       fetch_valid,
    input  logic             squash,
    input  logic             bus_grant,
    input  logic [3:0]       mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [3:0]       mem2proc_tag,
    input  logic [2:0][63:0] cm_data,
    input  logic [2:0]       cm_valid,
    output logic [2:0][4:0]  cm_read_index,
    output logic [2:0][7:0]  cm_read_tag,
    output logic             cm_write_en,
    output logic [4:0]       cm_write_index,
    output logic [7:0]       cm_write_tag,
    output logic [63:0]      cm_write_data,
    output logic [1:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [2:0][63:0] fetch_data,
    output logic [2:0]       fetch_hit
);

    localparam int LEFT_BITS = $clog2(PREFETCH_DEPTH + 2);
    localparam logic [LEFT_BITS-1:0] WINDOW_LEN = LEFT_BITS'(PREFETCH_DEPTH + 1);

    fill_state_t            state_q, state_d;
    logic [BLOCK_BITS-1:0]  req_block_q, req_block_d;
    logic [LEFT_BITS-1:0]   req_left_q, req_left_d;

    logic [2:0][BLOCK_BITS-1:0] lane_block;
    logic [2:0]                 lane_bypass;
    logic                       miss_valid;
    logic [BLOCK_BITS-1:0]      miss_block;
    logic                       miss_in_mshr;
    logic                       req_in_mshr;
    logic                       mshr_full;
    logic                       fill_hit;
    logic [BLOCK_BITS-1:0]      fill_block;
    logic                       alloc_en;
    logic                       advance;
    logic [BLOCK_BITS-1:0]      window_offset;
    logic                       in_window;
    logic                       new_miss;
    logic                       unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[0][31:16], fetch_pc[0][2:0],
                              fetch_pc[1][31:16], fetch_pc[1][2:0],
                              fetch_pc[2][31:16], fetch_pc[2][2:0]};

    icache_mshr_table #(.DEPTH(MSHR_DEPTH)) u_mshr (
        .clock          (clock),
        .reset          (reset),
        .alloc_en       (alloc_en),
        .alloc_tag      (mem2proc_response),
        .alloc_block    (req_block_q),
        .fill_tag       (mem2proc_tag),
        .fill_hit       (fill_hit),
        .fill_block     (fill_block),
        .lookup_block_a (miss_block),
        .lookup_hit_a   (miss_in_mshr),
        .lookup_block_b (req_block_q),
        .lookup_hit_b   (req_in_mshr),
        .full           (mshr_full)
    );

    assign cm_write_en    = fill_hit;
    assign cm_write_index = fill_block[ICACHE_INDEX_BITS-1:0];
    assign cm_write_tag   = fill_block[BLOCK_BITS-1:ICACHE_INDEX_BITS];
    assign cm_write_data  = mem2proc_data;

    // A block being written this cycle is forwarded straight to any lane
    // that wants it; only the oldest missing lane may start a request.
    always_comb begin
        miss_valid = 1'b0;
        miss_block = '0;
        for (int i = 0; i < 3; i++) begin
            lane_block[i]    = fetch_pc[i][15:3];
            cm_read_index[i] = fetch_pc[i][7:3];
            cm_read_tag[i]   = fetch_pc[i][15:8];
            lane_bypass[i]   = cm_write_en && (fill_block == lane_block[i]);
            fetch_hit[i]     = fetch_valid[i] & (cm_valid[i] | lane_bypass[i]);
            fetch_data[i]    = lane_bypass[i] ? mem2proc_data : cm_data[i];
            if (fetch_valid[i] && !fetch_hit[i] && !miss_valid) begin
                miss_valid = 1'b1;
                miss_block = lane_block[i];
            end
        end
    end

    assign window_offset = miss_block - req_block_q;
    assign in_window     = window_offset < {{(BLOCK_BITS-LEFT_BITS){1'b0}}, req_left_q};
    assign new_miss      = miss_valid && !miss_in_mshr && !in_window && !squash;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL_IDLE;
            req_block_q <= '0;
            req_left_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_block_q <= req_block_d;
            req_left_q  <= req_left_d;
        end
    end

    // Squash beats a new demand miss, which beats the remaining prefetches;
    // blocks already tracked are skipped without using the bus.
    always_comb begin
        state_d          = state_q;
        req_block_d      = req_block_q;
        req_left_d       = req_left_q;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        alloc_en         = 1'b0;
        advance          = 1'b0;
        if (squash) begin
            state_d    = FILL_IDLE;
            req_left_d = '0;
        end else if (new_miss) begin
            state_d     = FILL_ISSUE;
            req_block_d = miss_block;
            req_left_d  = WINDOW_LEN;
        end else if (state_q == FILL_ISSUE) begin
            if (req_in_mshr) begin
                advance = 1'b1;
            end else if (bus_grant && !mshr_full) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {16'b0, req_block_q, 3'b0};
                if (mem2proc_response != '0) begin
                    alloc_en = 1'b1;
                    advance  = 1'b1;
                end
            end
            if (advance) begin
                req_block_d = req_block_q + 1'b1;
                req_left_d  = req_left_q - 1'b1;
                if (req_left_q == LEFT_BITS'(1)) state_d = FILL_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: cold miss, fill bypass, reject retry,
// squash, MSHR full stall, block wrap and reset with late responses.
module tb_icache_fill_ctrl;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    logic             clock;
    logic             reset;
    logic [2:0][31:0] fetch_pc;
    logic [2:0]       fetch_valid;
    logic             squash;
    logic             bus_grant;
    logic [3:0]       mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [3:0]       mem2proc_tag;
    logic [2:0][63:0] cm_data;
    logic [2:0]       cm_valid;
    logic [2:0][4:0]  cm_read_index;
    logic [2:0][7:0]  cm_read_tag;
    logic             cm_write_en;
    logic [4:0]       cm_write_index;
    logic [7:0]       cm_write_tag;
    logic [63:0]      cm_write_data;
    logic [1:0]       proc2mem_command;
    logic [31:0]      proc2mem_addr;
    logic [2:0][63:0] fetch_data;
    logic [2:0]       fetch_hit;

    int checkCount;
    int errorCount;

    icache_fill_ctrl #(.MSHR_DEPTH(4), .PREFETCH_DEPTH(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid),
        .squash            (squash),
        .bus_grant         (bus_grant),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .cm_data           (cm_data),
        .cm_valid          (cm_valid),
        .cm_read_index     (cm_read_index),
        .cm_read_tag       (cm_read_tag),
        .cm_write_en       (cm_write_en),
        .cm_write_index    (cm_write_index),
        .cm_write_tag      (cm_write_tag),
        .cm_write_data     (cm_write_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .fetch_data        (fetch_data),
        .fetch_hit         (fetch_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc0, input logic [2:0] valid,
                                 input logic grant, input logic [3:0] response);
        fetch_pc[0]       = pc0;
        fetch_valid       = valid;
        bus_grant         = grant;
        mem2proc_response = response;
    endtask

    task automatic cycleEnd();
        @(posedge clock);
        #1;
    endtask

    task automatic checkBus(input string tag, input logic [1:0] cmd, input logic [31:0] addr);
        #2;
        checkOutput({tag, "_cmd"}, 64'(proc2mem_command), 64'(cmd));
        checkOutput({tag, "_addr"}, 64'(proc2mem_addr), 64'(addr));
    endtask

    task automatic checkFill(input string tag, input logic en, input logic [4:0] idx, input logic [7:0] ctag);
        #2;
        checkOutput({tag, "_wen"}, 64'(cm_write_en), 64'(en));
        if (en) begin
            checkOutput({tag, "_widx"}, 64'(cm_write_index), 64'(idx));
            checkOutput({tag, "_wtag"}, 64'(cm_write_tag), 64'(ctag));
        end
    endtask

    initial begin
        checkCount        = 0;
        errorCount        = 0;
        reset             = 1'b1;
        fetch_pc          = '0;
        fetch_valid       = 3'b011;
        squash            = 1'b0;
        bus_grant         = 1'b0;
        mem2proc_response = 4'd0;
        mem2proc_data     = 64'h0;
        mem2proc_tag      = 4'd0;
        cm_data           = '0;
        cm_valid          = 3'b010;
        fetch_pc[1]       = 32'h0000_ABCD;
        cm_data[1]        = 64'h1111_2222_3333_4444;

        // reset state and read-port addressing
        repeat (2) @(posedge clock);
        #1;
        checkBus("reset", CMD_NONE, 32'h0);
        checkOutput("reset_wen", 64'(cm_write_en), 64'd0);
        checkOutput("reset_hit", 64'(fetch_hit), 64'b010);
        checkOutput("read_index1", 64'(cm_read_index[1]), 64'h19);
        checkOutput("read_tag1", 64'(cm_read_tag[1]), 64'hAB);
        checkOutput("cm_data1", fetch_data[1], 64'h1111_2222_3333_4444);

        // cold miss: demand block plus two prefetches
        cm_valid = 3'b000;
        reset    = 1'b0;
        applyStimulus(32'h0000_0100, 3'b001, 1'b1, 4'd1);
        checkBus("cold_idle", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("cold_0", CMD_LOAD, 32'h100);
        cycleEnd();
        mem2proc_response = 4'd2;
        checkBus("cold_1", CMD_LOAD, 32'h108);
        cycleEnd();
        mem2proc_response = 4'd3;
        checkBus("cold_2", CMD_LOAD, 32'h110);
        cycleEnd();
        mem2proc_response = 4'd0;
        checkBus("cold_done", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("cold_covered", CMD_NONE, 32'h0);
        cycleEnd();

        // fill tag 2 with same-cycle bypass to the lane fetching 0x108
        fetch_pc[1]   = 32'h0000_0108;
        fetch_valid   = 3'b011;
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'hDEAD_BEEF_0000_0001;
        checkFill("fill2", 1'b1, 5'h01, 8'h01);
        checkOutput("fill2_data", cm_write_data, 64'hDEAD_BEEF_0000_0001);
        checkOutput("bypass_hit", 64'(fetch_hit), 64'b010);
        checkOutput("bypass_data", fetch_data[1], 64'hDEAD_BEEF_0000_0001);
        cycleEnd();
        fetch_valid = 3'b001;
        checkFill("stale_tag2", 1'b0, 5'h0, 8'h0);
        cycleEnd();
        mem2proc_tag = 4'd1;
        checkFill("fill1", 1'b1, 5'h00, 8'h01);
        checkOutput("fill1_hit", 64'(fetch_hit), 64'b001);
        cycleEnd();
        fetch_valid  = 3'b000;
        mem2proc_tag = 4'd3;
        checkFill("fill3", 1'b1, 5'h02, 8'h01);
        cycleEnd();
        mem2proc_tag = 4'd0;

        // rejected twice, accepted on the third try, then squash
        applyStimulus(32'h0000_0200, 3'b001, 1'b1, 4'd0);
        checkBus("rej_idle", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("rej_try0", CMD_LOAD, 32'h200);
        cycleEnd();
        checkBus("rej_try1", CMD_LOAD, 32'h200);
        cycleEnd();
        mem2proc_response = 4'd5;
        checkBus("rej_accept", CMD_LOAD, 32'h200);
        cycleEnd();
        mem2proc_response = 4'd6;
        checkBus("rej_next", CMD_LOAD, 32'h208);
        cycleEnd();
        mem2proc_response = 4'd7;
        squash            = 1'b1;
        checkBus("squash_cycle", CMD_NONE, 32'h0);
        cycleEnd();
        squash            = 1'b0;
        mem2proc_response = 4'd0;
        fetch_valid       = 3'b000;
        checkBus("squash_after", CMD_NONE, 32'h0);
        cycleEnd();
        mem2proc_tag = 4'd5;
        checkFill("squash_fill5", 1'b1, 5'h00, 8'h02);
        cycleEnd();
        mem2proc_tag = 4'd6;
        checkFill("squash_fill6", 1'b1, 5'h01, 8'h02);
        cycleEnd();
        mem2proc_tag = 4'd7;
        checkFill("squash_tag7", 1'b0, 5'h0, 8'h0);
        cycleEnd();
        mem2proc_tag = 4'd0;

        // fill all four MSHRs, stall, then resume one cycle after a fill
        applyStimulus(32'h0000_0300, 3'b001, 1'b1, 4'd1);
        checkBus("full_idle", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("full_a0", CMD_LOAD, 32'h300);
        cycleEnd();
        mem2proc_response = 4'd2;
        checkBus("full_a1", CMD_LOAD, 32'h308);
        cycleEnd();
        mem2proc_response = 4'd3;
        checkBus("full_a2", CMD_LOAD, 32'h310);
        cycleEnd();
        fetch_pc[0]       = 32'h0000_0400;
        mem2proc_response = 4'd4;
        checkBus("full_idle2", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("full_b0", CMD_LOAD, 32'h400);
        cycleEnd();
        mem2proc_response = 4'd9;
        checkBus("full_stall0", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("full_stall1", CMD_NONE, 32'h0);
        cycleEnd();
        mem2proc_tag = 4'd2;
        checkFill("full_fill2", 1'b1, 5'h01, 8'h03);
        checkOutput("full_fill_cmd", 64'(proc2mem_command), 64'(CMD_NONE));
        cycleEnd();
        mem2proc_tag      = 4'd0;
        mem2proc_response = 4'd8;
        checkBus("full_resume", CMD_LOAD, 32'h408);
        cycleEnd();
        mem2proc_response = 4'd9;
        checkBus("full_again", CMD_NONE, 32'h0);

        // reset mid-operation drops every tracked request
        reset = 1'b1;
        cycleEnd();
        checkBus("rst_mid", CMD_NONE, 32'h0);
        reset       = 1'b0;
        fetch_valid = 3'b000;
        mem2proc_tag = 4'd1;
        checkFill("rst_late1", 1'b0, 5'h0, 8'h0);
        cycleEnd();
        mem2proc_tag = 4'd4;
        checkFill("rst_late4", 1'b0, 5'h0, 8'h0);
        cycleEnd();
        mem2proc_tag = 4'd0;

        // block 0x1FFF wraps to block 0, reset while issuing
        applyStimulus(32'h0000_FFF8, 3'b001, 1'b1, 4'd1);
        checkBus("wrap_idle", CMD_NONE, 32'h0);
        cycleEnd();
        checkBus("wrap_0", CMD_LOAD, 32'hFFF8);
        cycleEnd();
        mem2proc_response = 4'd2;
        checkBus("wrap_1", CMD_LOAD, 32'h0000);
        cycleEnd();
        mem2proc_response = 4'd0;
        checkBus("wrap_2", CMD_LOAD, 32'h0008);
        reset = 1'b1;
        cycleEnd();
        checkBus("wrap_rst", CMD_NONE, 32'h0);
        reset        = 1'b0;
        fetch_valid  = 3'b000;
        mem2proc_tag = 4'd2;
        checkFill("wrap_late2", 1'b0, 5'h0, 8'h0);
        cycleEnd();
        mem2proc_tag = 4'd0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Miss-handling and fill controller for the 3-wide instruction cache. It drives the data store's three read ports from fetch PCs, detects misses, and issues block loads plus sequential prefetches on the shared memory bus. It tracks outstanding requests by memory tag and writes returning blocks into the data store, which makes it the writer side of the store's fill port. It sits between fetch, the data store, and the memory-bus arbiter.

Parameters:
MSHR_DEPTH, 4, number of outstanding memory requests tracked (1..15)
PREFETCH_DEPTH, 2, sequential blocks requested after a demand-miss block

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_pc  in  3x32  PCs for lanes 0..2; lane 0 is oldest
fetch_valid  in  3  lane request valid
squash  in  1  redirect; cancels pending demand/prefetch issue
bus_grant  in  1  arbiter grants the memory bus this cycle
mem2proc_response  in  4  memory tag of an accepted request; 0 = rejected
mem2proc_data  in  64  returning block data
mem2proc_tag  in  4  tag of returning data; 0 = none
cm_data  in  3x64  data-store read data
cm_valid  in  3  data-store hit per lane
cm_read_index  out  3x5  fetch_pc[i][7:3]
cm_read_tag  out  3x8  fetch_pc[i][15:8]
cm_write_en  out  1  fill data-store line
cm_write_index  out  5  fill index
cm_write_tag  out  8  fill tag
cm_write_data  out  64  fill data (= mem2proc_data)
proc2mem_command  out  2  BUS_NONE or BUS_LOAD
proc2mem_addr  out  32  {16'b0, block[12:0], 3'b0}
fetch_data  out  3x64  instruction block per lane
fetch_hit  out  3  lane data valid

Behaviour:
- Block address is pc[15:3]: index = pc[7:3], tag = pc[15:8].
- Per-lane hit = fetch_valid & (cm_valid | fill bypass).
- Fill bypass: when cm_write_en is high and {cm_write_tag, cm_write_index} equals the lane's block, fetch_hit is 1 and fetch_data = mem2proc_data in the same cycle.
- Demand miss: the lowest-numbered lane with fetch_valid and no hit. Only that lane's block is a miss candidate.
- MSHR entry fields: valid, mem_tag[3:0], block[12:0].
- "Covered" means the block is in a valid MSHR entry or inside the current request window.
- FSM states:
  - IDLE: a demand miss that is not covered loads req_block = miss block and req_left = PREFETCH_DEPTH+1, then moves to ISSUE.
  - ISSUE: drive BUS_LOAD at req_block when bus_grant is high, a free MSHR exists, and req_block is not already in a valid MSHR (duplicate → skip: advance without issuing).
    - Accept (response != 0): allocate the lowest free entry with the response tag; req_block += 1 (13-bit wrap); req_left -= 1; when req_left reaches 0, go to IDLE.
    - Reject (response == 0): hold and retry next cycle.
    - No free entry or no grant: BUS_NONE, hold.
    - A new uncovered demand miss restarts the window at the miss block (demand priority over remaining prefetches).
- proc2mem_command is BUS_NONE whenever not issuing. proc2mem_command/addr are combinational from state; response is sampled in the same cycle.
- Fill: a nonzero mem2proc_tag matching a valid entry gives cm_write_en=1 with that entry's index/tag, and the entry is freed that cycle. A non-matching tag is ignored.
- Simultaneous fill free and allocate: a freed entry is not reusable until the next cycle.
- squash: goes to IDLE and clears req_left. Valid MSHR entries are kept, so outstanding fills still complete and write.
- Reset: FSM IDLE, all MSHR entries invalid, req_left 0. Outputs after reset: cm_write_en 0, proc2mem_command BUS_NONE, proc2mem_addr 0. fetch_hit reflects only cm_valid.
- Reset mid-operation: in-flight responses arriving after reset are ignored because no entry matches.

Decomposition:
- Shared package: BUS_NONE/BUS_LOAD encodings, the ICACHE_INDEX_BITS=5 / ICACHE_TAG_BITS=8 constants, and an mshr_entry_t struct.
- Sub-module icache_mshr_table: allocate, tag-match free, block-match lookup, free/full flags.

Test Plan:
- Cold miss, lane0 PC 0x0000_0100, grant=1, responses 1,2,3 → loads at 0x100, 0x108, 0x110 on consecutive cycles, three MSHRs valid, then IDLE.
- mem2proc_tag=2 with data 0xDEAD_BEEF_0000_0001 → cm_write_en=1, index 0x01, tag 0x01; the lane fetching 0x108 hits the same cycle via bypass.
- Response 0 for two cycles, then 5 → the same address held for 3 cycles; MSHR gets tag 5 and req_block advances once.
- MSHR_DEPTH=4, all full → BUS_NONE until a fill frees an entry; issue resumes the following cycle.
- squash during ISSUE with 2 outstanding → no further loads; both tags still fill the data store.
- Block 0x1FFF miss, PREFETCH_DEPTH=2 → requests 0xFFF8, 0x0000, 0x0008 (wrap); reset mid-issue → BUS_NONE next cycle and a late tag produces no write.
